// File: rtl/psg_stereo_mixer_if.sv
// psg_stereo_mixer_if: PSG sample inputs and stereo audio outputs of the mixer.
interface psg_stereo_mixer_if;
   logic ce_sample;
   logic [7:0] psg_a;
   logic [7:0] psg_b;
   logic [7:0] psg_c;
   logic [9:0] psg_mono;
   logic [1:0] stereo_mode;
   logic [15:0] audio_l;
   logic [15:0] audio_r;
   logic sample_valid;
   logic fading;
   modport master (
      output ce_sample, psg_a, psg_b, psg_c, psg_mono, stereo_mode,
      input audio_l, audio_r, sample_valid, fading
   );
   modport slave (
      input ce_sample, psg_a, psg_b, psg_c, psg_mono, stereo_mode,
      output audio_l, audio_r, sample_valid, fading
   );
endinterface

// File: rtl/psg_stereo_mixer.sv
// psg_stereo_mixer: PSG ABC/ACB/mono stereo mixer with click-free fade on mode change.
// Optional one-pole output low-pass when PSG_STEREO_MIXER_LPF_EN is defined.
module psg_stereo_mixer (
   input logic clk_sys,
   input logic reset_n,
   psg_stereo_mixer_if.slave bus
);
   typedef enum logic [1:0] {RUN, FADE_OUT, SWITCH, FADE_IN} state_t;
   state_t state, state_nx;
   logic [4:0] gain, gain_nx, gain_dn;
   logic [1:0] active_mode, active_nx, pending_mode, pending_nx;
   logic [7:0] a, b, c;
   logic [9:0] mono, sum_l, sum_r;
   logic [1:0] mode;
   logic v1, v2;
   logic [15:0] mix_l, mix_r, g_l, g_r;
   logic [20:0] prod_l, prod_r;

   assign sum_l = active_mode == 2'b01 ? {2'b0, a} + {2'b0, b} :
                  active_mode == 2'b10 ? {2'b0, a} + {2'b0, c} : mono;
   assign sum_r = active_mode[0] ^ active_mode[1] ? {2'b0, c} + {2'b0, b} : mono;
   assign prod_l = {5'd0, mix_l} * {16'd0, gain};
   assign prod_r = {5'd0, mix_r} * {16'd0, gain};
   assign g_l = 16'(prod_l >> 4);
   assign g_r = 16'(prod_r >> 4);
   assign gain_dn = gain == 5'd0 ? 5'd0 : gain - 5'd1;
   assign bus.fading = state != RUN;

   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         a <= '0;
         b <= '0;
         c <= '0;
         mono <= '0;
         mode <= '0;
         mix_l <= '0;
         mix_r <= '0;
      end else begin
         v1 <= bus.ce_sample;
         v2 <= v1;
         if (bus.ce_sample) begin
            a <= bus.psg_a;
            b <= bus.psg_b;
            c <= bus.psg_c;
            mono <= bus.psg_mono;
            mode <= bus.stereo_mode;
         end
         if (v1) begin
            mix_l <= {sum_l, 6'b0};
            mix_r <= {sum_r, 6'b0};
         end
      end

   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) begin
         state <= RUN;
         gain <= 5'd16;
         active_mode <= 2'b00;
         pending_mode <= 2'b00;
      end else begin
         state <= state_nx;
         gain <= gain_nx;
         active_mode <= active_nx;
         pending_mode <= pending_nx;
      end

   // the mix stage reads active_mode before this update, so the switch is hidden under gain 0
   always_comb begin
      state_nx = state;
      gain_nx = gain;
      active_nx = active_mode;
      pending_nx = pending_mode;
      if (v1 && state == SWITCH) begin
         active_nx = pending_mode;
         gain_nx = 5'd0;
         state_nx = FADE_IN;
      end else if (v1 && (state == FADE_OUT || mode != active_mode)) begin
         pending_nx = mode;
         gain_nx = gain_dn;
         state_nx = gain_dn == 5'd0 ? SWITCH : FADE_OUT;
      end else if (v1 && state == FADE_IN) begin
         gain_nx = gain + 5'd1;
         state_nx = gain == 5'd15 ? RUN : FADE_IN;
      end
   end

`ifdef PSG_STEREO_MIXER_LPF_EN
   logic v3;
   logic signed [17:0] y_l, y_r, yn_l, yn_r;

   function automatic logic [15:0] sat(input logic signed [17:0] v);
      return v[17] ? 16'd0 : v[16] ? 16'hFFFF : v[15:0];
   endfunction

   assign yn_l = y_l + ((signed'({2'b0, g_l}) - y_l) >>> 2);
   assign yn_r = y_r + ((signed'({2'b0, g_r}) - y_r) >>> 2);

   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) begin
         v3 <= 1'b0;
         y_l <= '0;
         y_r <= '0;
         bus.sample_valid <= 1'b0;
         bus.audio_l <= '0;
         bus.audio_r <= '0;
      end else begin
         v3 <= v2;
         bus.sample_valid <= v3;
         if (v2) begin
            y_l <= yn_l;
            y_r <= yn_r;
         end
         if (v3) begin
            bus.audio_l <= sat(y_l);
            bus.audio_r <= sat(y_r);
         end
      end
`else
   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) begin
         bus.sample_valid <= 1'b0;
         bus.audio_l <= '0;
         bus.audio_r <= '0;
      end else begin
         bus.sample_valid <= v2;
         if (v2) begin
            bus.audio_l <= g_l;
            bus.audio_r <= g_r;
         end
      end
`endif
endmodule

// File: tb/tb_psg_stereo_mixer.sv
// tb_psg_stereo_mixer: directed vectors against a per-sample behavioural model of the mixer.
module tb_psg_stereo_mixer;
   logic clk_sys = 1'b0;
   logic reset_n = 1'b0;
   psg_stereo_mixer_if bus();
   psg_stereo_mixer dut (.clk_sys(clk_sys), .reset_n(reset_n), .bus(bus));
   always #5 clk_sys = ~clk_sys;

`ifdef PSG_STEREO_MIXER_LPF_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 3;
`endif

   typedef struct {
      int due;
      int l;
      int r;
   } exp_t;
   exp_t q[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_l = 0;
   int last_r = 0;
   // model: phase 0 steady, 1 fading out, 2 switching, 3 fading in
   int m_phase = 0;
   int m_gain = 16;
   int m_active = 0;
   int m_pending = 0;
   int yl = 0;
   int yr = 0;

   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic lit(input string name, input int act, input int req);
`ifndef PSG_STEREO_MIXER_LPF_EN
      chk(name, act, req);
`endif
   endtask

   task automatic rst_pulse();
      reset_n = 1'b0;
      #1;
      chk("rst_audio_l", bus.audio_l, 0);
      chk("rst_audio_r", bus.audio_r, 0);
      chk("rst_valid", bus.sample_valid, 0);
      chk("rst_fading", bus.fading, 0);
      q.delete();
      m_phase = 0;
      m_gain = 16;
      m_active = 0;
      m_pending = 0;
      yl = 0;
      yr = 0;
      @(negedge clk_sys);
      reset_n = 1'b1;
   endtask

   task automatic send(input logic [7:0] a, b, c, input logic [9:0] mono, input logic [1:0] mode,
                       input bit abort = 1'b0);
      int pa, sl, sr, xl, xr;
      exp_t e;
      pa = m_active;
      if (m_phase == 2) begin
         m_active = m_pending;
         m_phase = 3;
      end else if (m_phase == 1 || int'(mode) != m_active) begin
         m_pending = mode;
         m_gain = m_gain > 0 ? m_gain - 1 : 0;
         m_phase = m_gain == 0 ? 2 : 1;
      end else if (m_phase == 3) begin
         m_gain++;
         if (m_gain == 16) m_phase = 0;
      end
      sl = pa == 1 ? a + b : pa == 2 ? a + c : int'(mono);
      sr = (pa == 1 || pa == 2) ? c + b : int'(mono);
      xl = sl * 64 * m_gain / 16;
      xr = sr * 64 * m_gain / 16;
`ifdef PSG_STEREO_MIXER_LPF_EN
      yl = yl + ((xl - yl) >>> 2);
      yr = yr + ((xr - yr) >>> 2);
      xl = yl < 0 ? 0 : yl > 65535 ? 65535 : yl;
      xr = yr < 0 ? 0 : yr > 65535 ? 65535 : yr;
`endif
      @(negedge clk_sys);
      bus.ce_sample = 1'b1;
      bus.psg_a = a;
      bus.psg_b = b;
      bus.psg_c = c;
      bus.psg_mono = mono;
      bus.stereo_mode = mode;
      e.due = cyc + LAT;
      e.l = xl;
      e.r = xr;
      q.push_back(e);
      @(negedge clk_sys);
      bus.ce_sample = 1'b0;
      bus.psg_a = 8'h5A;
      bus.psg_mono = 10'h2C3;
      bus.stereo_mode = ~mode;
      if (abort) rst_pulse();
      else begin
         repeat (3) @(negedge clk_sys);
         chk("fading", bus.fading, int'(m_phase != 0));
      end
   endtask

   initial forever begin
      @(posedge clk_sys);
      #1;
      if (q.size() > 0 && q[0].due == cyc) begin
         chk("sample_valid", bus.sample_valid, 1);
         chk("audio_l", bus.audio_l, q[0].l);
         chk("audio_r", bus.audio_r, q[0].r);
         last_l = bus.audio_l;
         last_r = bus.audio_r;
         void'(q.pop_front());
      end else chk("idle_valid", bus.sample_valid, 0);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.ce_sample = 1'b0;
      bus.psg_a = '0;
      bus.psg_b = '0;
      bus.psg_c = '0;
      bus.psg_mono = '0;
      bus.stereo_mode = '0;
      repeat (2) @(negedge clk_sys);
      chk("init_audio_l", bus.audio_l, 0);
      chk("init_audio_r", bus.audio_r, 0);
      chk("init_valid", bus.sample_valid, 0);
      chk("init_fading", bus.fading, 0);
      reset_n = 1'b1;
      send(8'h00, 8'h00, 8'h00, 10'h3FF, 2'b00);
      lit("mono_full_l", last_l, 16'hFFC0);
      lit("mono_full_r", last_r, 16'hFFC0);
`ifdef PSG_STEREO_MIXER_LPF_EN
      chk("lpf_step1", last_l, 16'h3FF0);
`endif
      send(8'h12, 8'h34, 8'h56, 10'h155, 2'b00);
      lit("mono_155", last_l, 16'h5540);
      send(8'hFF, 8'hFF, 8'hFF, 10'h001, 2'b00);
      send(8'hFF, 8'hFF, 8'hFF, 10'h000, 2'b00);
      repeat (33) send(8'h80, 8'h40, 8'h20, 10'h2AA, 2'b01);
      chk("abc_settled", bus.fading, 0);
      send(8'hFF, 8'h01, 8'h10, 10'h000, 2'b01);
      lit("abc_l", last_l, 16'h4000);
      lit("abc_r", last_r, 16'h0440);
      repeat (33) send(8'h40, 8'h20, 8'h10, 10'h100, 2'b10);
      for (int i = 1; i <= 33; i++) begin
         send(8'h40, 8'h20, 8'h10, 10'h100, 2'b01);
         if (i == 1) lit("fade_s1_l", last_l, 16'h12C0);
         if (i == 1) chk("fade_rise", bus.fading, 1);
         if (i == 16) lit("fade_s16_l", last_l, 16'h0000);
         if (i == 17) lit("switch_l", last_l, 16'h0000);
         if (i == 18) lit("fade_s18_l", last_l, 16'h0180);
         if (i == 32) chk("fade_s32", bus.fading, 1);
         if (i == 33) lit("fade_s33_l", last_l, 16'h1800);
         if (i == 33) chk("fade_fall", bus.fading, 0);
      end
      for (int i = 1; i <= 26; i++) begin
         send(8'h40, 8'h20, 8'h10, 10'h100, i == 26 ? 2'b11 : 2'b10);
         if (i == 25) lit("fadein_g8_l", last_l, 16'h0A00);
         if (i == 26) lit("refade_g7_l", last_l, 16'h08C0);
         if (i == 26) lit("refade_g7_r", last_r, 16'h0540);
      end
      repeat (24) send(8'h40, 8'h20, 8'h10, 10'h100, 2'b11);
      send(8'h40, 8'h20, 8'h10, 10'h100, 2'b11);
      lit("mode11_mono", last_l, 16'h4000);
      chk("mode11_settled", bus.fading, 0);
      for (int i = 1; i <= 33; i++) begin
         send(8'h40, 8'h20, 8'h10, 10'h100, i <= 3 ? 2'b01 : 2'b11);
         if (i == 32) chk("writeback_s32", bus.fading, 1);
         if (i == 33) chk("writeback_s33", bus.fading, 0);
      end
      repeat (5) send(8'h40, 8'h20, 8'h10, 10'h100, 2'b00);
      chk("pre_reset_fading", bus.fading, 1);
      send(8'h40, 8'h20, 8'h10, 10'h100, 2'b00, 1'b1);
      repeat (4) @(negedge clk_sys);
      send(8'h00, 8'h00, 8'h00, 10'h3FF, 2'b00);
      lit("post_reset_l", last_l, 16'hFFC0);
      chk("post_reset_fading", bus.fading, 0);
      send(8'h10, 8'h20, 8'h30, 10'h200, 2'b01);
      chk("post_reset_fade", bus.fading, 1);
      lit("post_reset_fade_l", last_l, 16'h7800);
      send(8'h10, 8'h20, 8'h30, 10'h200, 2'b01);
      repeat (4) @(negedge clk_sys);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
